wddl_phase_ctrl: RTL and testbench
==================================

Name: wddl_phase_ctrl

Overview:
- Precharge/evaluate phase sequencer for a bank of WDDL dual-rail registers.
- Drives the shared prechrg signal into the precharge input stages and a capture enable for the dual-rail flop pairs.
- Sequences PRECHARGE -> EVALUATE -> CAPTURE rounds, single-shot or continuous.
- Monitors the captured q/qbar rails for dual-rail violations.

Parameters:
- WIDTH, 8: number of dual-rail flop pairs monitored.
- PRE_CYC, 2: precharge phase length in clk cycles, range 1..15.
- EVAL_CYC, 2: evaluate phase length in clk cycles, range 1..15.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a round; sampled only in IDLE.
- cont_i  in  1  continuous mode; sampled at the end of CAPT.
- stop_i  in  1  terminate continuous operation after the current CAPT.
- clr_err_i  in  1  clear sticky error flag and error counter.
- q_i  in  WIDTH  true rails from the flop pairs.
- qbar_i  in  WIDTH  false rails from the flop pairs.
- prechrg_o  out  1  1 = precharge (both rails forced low), 0 = evaluate.
- cap_en_o  out  1  capture strobe to the dual-rail register bank.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on the cycle after CAPT.
- rail_err_o  out  1  sticky dual-rail violation flag.
- err_cnt_o  out  ERR_W  violation count, saturating.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, prechrg_o=1, cap_en_o=0, busy_o=0, done_o=0, rail_err_o=0, err_cnt_o=0.
- Reset asserted mid-round returns to IDLE on the next edge with these values; it overrides every other input.
- IDLE: prechrg_o=1. start_i=1 -> PRE, with the phase counter loaded to PRE_CYC-1.
- PRE: prechrg_o=1 for exactly PRE_CYC cycles; counter decrements. At 0 -> EVAL, counter loaded to EVAL_CYC-1.
- EVAL: prechrg_o=0 for exactly EVAL_CYC cycles. At 0 -> CAPT.
- CAPT: exactly 1 cycle; prechrg_o=0, cap_en_o=1.
- Exit from CAPT:
  - stop_i=1 or cont_i=0 -> IDLE.
  - Otherwise -> PRE. prechrg_o rises again on the cycle after CAPT.
  - If stop_i and cont_i are both 1, stop_i wins.
- done_o: pulses 1 cycle on the first cycle after every CAPT, whether the next state is IDLE or PRE.
- start_i while busy is ignored; no queuing.
- Round latency, start_i to cap_en_o: PRE_CYC+EVAL_CYC+1 cycles.
- Rail check, precharge: on the last PRE cycle, every bit must have q_i=0 and qbar_i=0.
- Rail check, evaluate: during CAPT, every bit must satisfy q_i XOR qbar_i = 1.
- Violation handling: any violating bit sets rail_err_o=1 on the next edge and increments err_cnt_o by 1. Increment is 1 per check cycle, regardless of how many bits fail.
- err_cnt_o saturates at 2^ERR_W-1.
- clr_err_i=1 zeroes both rail_err_o and err_cnt_o. If a violation occurs in the same cycle, the clear wins.
- Out-of-range PRE_CYC or EVAL_CYC is a configuration error; behaviour is not guaranteed.

Optional Feature:
- Macro: WDDL_RAIL_CHECK_EN.
- Defined: rail checking, rail_err_o and err_cnt_o behave as above.
- Undefined: the checker logic is removed; rail_err_o and err_cnt_o are tied to 0; q_i, qbar_i and clr_err_i are unused.
- Sequencing is identical in both builds.

Test Plan:
- Reset, then start_i pulse, PRE_CYC=2, EVAL_CYC=2, cont_i=0:
  - prechrg_o=1 for 2 cycles, then 0 for 3 cycles.
  - cap_en_o=1 on the 5th cycle after start.
  - done_o=1 on the 6th cycle; IDLE after.
- Continuous mode: cont_i=1 for 3 rounds, then stop_i=1 during the 3rd CAPT:
  - Exactly 3 cap_en_o pulses, spaced 5 cycles apart.
  - 3 done_o pulses.
  - busy_o falls after the 3rd round.
- rst asserted during EVAL: next edge gives prechrg_o=1, busy_o=0, cap_en_o=0; a later start_i gives a full-length round.
- With WDDL_RAIL_CHECK_EN: q_i=qbar_i=8'h01 during CAPT:
  - rail_err_o=1 and err_cnt_o=1.
  - A second failing round gives err_cnt_o=2.
  - clr_err_i gives 0/0.
- With WDDL_RAIL_CHECK_EN: q_i=8'h80, qbar_i=8'h00 on the last PRE cycle -> violation counted. Correct complementary data (q_i=8'hA5, qbar_i=8'h5A) -> no flag.
- Counter saturation with ERR_W=2: 5 failing rounds -> err_cnt_o stays at 3.

Source files
------------

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate phase sequencer for a bank of WDDL dual-rail registers.
// Latency: start to cap_en is PRE_CYC+EVAL_CYC+1 cycles; done pulses the cycle after CAPT.
// Backpressure: none; start while busy is dropped (no queuing), stop ends continuous mode after CAPT.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, cont, stop      round request, continuous mode, end continuous mode
//   clr_err                clear sticky flag and violation counter
//   q, qbar                true/false rails from the dual-rail flop pairs (WIDTH bits)
//   prechrg                1 = precharge (rails forced low), 0 = evaluate
//   cap_en                 capture strobe to the dual-rail register bank
//   busy, done             not-IDLE indicator, one-cycle end-of-round pulse
//   rail_err, err_cnt      sticky dual-rail violation flag, saturating count
//
// Build option: define WDDL_RAIL_CHECK_EN to include the rail checker; without it
// rail_err_o/err_cnt_o are tied low and q_i/qbar_i/clr_err_i are ignored.
module wddl_phase_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRE_CYC  = 2,
    parameter int EVAL_CYC = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             stop_i,
    input  logic             clr_err_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] qbar_i,
    output logic             prechrg_o,
    output logic             cap_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             rail_err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        CAPT = 2'd3
    } state_t;

    // Phase counters are loaded with length-1 and count down to 0.
    localparam logic [3:0] PRE_LOAD  = 4'(PRE_CYC - 1);
    localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYC - 1);

    state_t     state;
    logic [3:0] cnt;

    // Outputs are produced alongside the next state so each one reflects the
    // state the sequencer is in during that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prechrg_o <= 1'b1;
            cap_en_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            cap_en_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= PRE;
                        cnt       <= PRE_LOAD;
                        prechrg_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == 4'd0) begin
                        state     <= EVAL;
                        cnt       <= EVAL_LOAD;
                        prechrg_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                EVAL: begin
                    if (cnt == 4'd0) begin
                        state    <= CAPT;
                        cap_en_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPT: begin
                    done_o    <= 1'b1;
                    prechrg_o <= 1'b1;
                    // stop has priority over cont.
                    if (stop_i || !cont_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state <= PRE;
                        cnt   <= PRE_LOAD;
                    end
                end
                default: begin
                    state     <= IDLE;
                    prechrg_o <= 1'b1;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

`ifdef WDDL_RAIL_CHECK_EN
    // Last precharge cycle: both rails of every pair must be low.
    // Capture cycle: every pair must carry exactly one high rail.
    logic pre_viol;
    logic capt_viol;
    logic viol;

    assign pre_viol  = (state == PRE) && (cnt == 4'd0) && (|(q_i | qbar_i));
    assign capt_viol = (state == CAPT) && !(&(q_i ^ qbar_i));
    assign viol      = pre_viol || capt_viol;

    // One increment per check cycle no matter how many bits fail; clear beats
    // a simultaneous violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rail_err_o <= 1'b0;
            err_cnt_o  <= '0;
        end else if (clr_err_i) begin
            rail_err_o <= 1'b0;
            err_cnt_o  <= '0;
        end else if (viol) begin
            rail_err_o <= 1'b1;
            if (err_cnt_o != {ERR_W{1'b1}}) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end
`else
    logic unused_rail;
    assign unused_rail = ^{q_i, qbar_i, clr_err_i};
    assign rail_err_o  = 1'b0;
    assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// Directed bench for wddl_phase_ctrl: single-shot rounds, continuous mode with
// stop, reset mid-round, rail violation flag/count/clear and counter saturation.
// Rails follow prechrg (low in precharge, complementary data in evaluate)
// unless a cycle explicitly forces other values onto them.
module tb_wddl_phase_ctrl;

`ifdef WDDL_RAIL_CHECK_EN
    localparam int RC = 1;
`else
    localparam int RC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       cont_i;
    logic       stop_i;
    logic       clr_err_i;
    logic [7:0] q_i;
    logic [7:0] qbar_i;

    logic       prechrg_o, cap_en_o, busy_o, done_o, rail_err_o;
    logic [7:0] err_cnt_o;
    logic       s_prechrg, s_cap_en, s_busy, s_done, s_rail_err;
    logic [1:0] s_err_cnt;

    logic       force_en;
    logic [7:0] fq, fqb;
    logic [7:0] dat;

    logic [5:0] exp_pre, exp_cap, exp_done, exp_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        q_i    = 8'h00;
        qbar_i = 8'h00;
        if (force_en) begin
            q_i    = fq;
            qbar_i = fqb;
        end else if (!prechrg_o) begin
            q_i    = dat;
            qbar_i = ~dat;
        end
    end

    wddl_phase_ctrl #(.WIDTH(8), .PRE_CYC(2), .EVAL_CYC(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .stop_i(stop_i),
        .clr_err_i(clr_err_i), .q_i(q_i), .qbar_i(qbar_i),
        .prechrg_o(prechrg_o), .cap_en_o(cap_en_o), .busy_o(busy_o), .done_o(done_o),
        .rail_err_o(rail_err_o), .err_cnt_o(err_cnt_o)
    );

    wddl_phase_ctrl #(.WIDTH(8), .PRE_CYC(2), .EVAL_CYC(2), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .stop_i(stop_i),
        .clr_err_i(clr_err_i), .q_i(q_i), .qbar_i(qbar_i),
        .prechrg_o(s_prechrg), .cap_en_o(s_cap_en), .busy_o(s_busy), .done_o(s_done),
        .rail_err_o(s_rail_err), .err_cnt_o(s_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-shot round started from IDLE. Cycle c counts edges after start is
    // sampled; force_cyc/clr_cyc drive the rails/clear into the edge ending
    // cycle c (2 = last PRE cycle, 5 = CAPT). A start pulse in mid-PRE must be ignored.
    task automatic round(input string tag, input int force_cyc, input logic [7:0] fq_v,
                         input logic [7:0] fqb_v, input int clr_cyc);
        start_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_i   = (c == 2);
            chk({tag, ".prechrg"}, 32'(prechrg_o), 32'(exp_pre[c-1]));
            chk({tag, ".cap_en"},  32'(cap_en_o),  32'(exp_cap[c-1]));
            chk({tag, ".done"},    32'(done_o),    32'(exp_done[c-1]));
            chk({tag, ".busy"},    32'(busy_o),    32'(exp_busy[c-1]));
            force_en  = (c == force_cyc);
            fq        = fq_v;
            fqb       = fqb_v;
            clr_err_i = (c == clr_cyc);
        end
        force_en  = 1'b0;
        clr_err_i = 1'b0;
        start_i   = 1'b0;
    endtask

    task automatic clear_errs();
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
    endtask

    initial begin
        exp_pre  = 6'b100011;
        exp_cap  = 6'b010000;
        exp_done = 6'b100000;
        exp_busy = 6'b011111;
        dat      = 8'h3C;
        rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; stop_i = 1'b0; clr_err_i = 1'b0;
        force_en = 1'b0; fq = 8'h00; fqb = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst.prechrg", 32'(prechrg_o), 32'd1);
        chk("rst.cap_en",  32'(cap_en_o),  32'd0);
        chk("rst.busy",    32'(busy_o),    32'd0);
        chk("rst.done",    32'(done_o),    32'd0);
        chk("rst.rail_err", 32'(rail_err_o), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt_o), 32'd0);

        // Single-shot round with clean rails
        round("single", 0, 8'h00, 8'h00, 0);
        tick();
        chk("single.idle_busy", 32'(busy_o), 32'd0);
        chk("single.no_err", 32'(rail_err_o), 32'd0);

        // Continuous: caps at 5,10,15, stop raised during the third CAPT
        cont_i  = 1'b1;
        start_i = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            start_i = 1'b0;
            chk("cont.cap_en",  32'(cap_en_o), 32'(c == 5 || c == 10 || c == 15));
            chk("cont.done",    32'(done_o),   32'(c == 6 || c == 11 || c == 16));
            chk("cont.busy",    32'(busy_o),   32'(c <= 15));
            chk("cont.prechrg", 32'(prechrg_o),
                32'(c >= 16 || ((c - 1) % 5) < 2));
            stop_i = (c == 15);
        end
        stop_i = 1'b0;
        cont_i = 1'b0;

        // Reset during EVAL, then a full-length round
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("mid.in_eval", 32'(prechrg_o), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.prechrg", 32'(prechrg_o), 32'd1);
        chk("mid.busy",    32'(busy_o),    32'd0);
        chk("mid.cap_en",  32'(cap_en_o),  32'd0);
        chk("mid.done",    32'(done_o),    32'd0);
        round("after_rst", 0, 8'h00, 8'h00, 0);

        // Both rails high in CAPT, twice, then clear
        round("capt_bad1", 5, 8'h01, 8'h01, 0);
        chk("capt_bad1.err", 32'(rail_err_o), 32'(RC));
        chk("capt_bad1.cnt", 32'(err_cnt_o),  32'(RC));
        round("capt_bad2", 5, 8'h01, 8'h01, 0);
        chk("capt_bad2.cnt", 32'(err_cnt_o),  32'(2 * RC));
        clear_errs();
        chk("clr.err", 32'(rail_err_o), 32'd0);
        chk("clr.cnt", 32'(err_cnt_o),  32'd0);

        // Rail high on the last precharge cycle
        round("pre_bad", 2, 8'h80, 8'h00, 0);
        chk("pre_bad.err", 32'(rail_err_o), 32'(RC));
        chk("pre_bad.cnt", 32'(err_cnt_o),  32'(RC));
        clear_errs();

        // Correct complementary data in CAPT
        round("good", 5, 8'hA5, 8'h5A, 0);
        chk("good.err", 32'(rail_err_o), 32'd0);
        chk("good.cnt", 32'(err_cnt_o),  32'd0);

        // Clear coinciding with a violation: clear wins
        round("clr_win", 5, 8'h01, 8'h01, 5);
        chk("clr_win.err", 32'(rail_err_o), 32'd0);
        chk("clr_win.cnt", 32'(err_cnt_o),  32'd0);

        // Five failing rounds: 8-bit counter reaches 5, 2-bit counter holds at 3
        for (int r = 0; r < 5; r++) begin
            round("sat", 5, 8'hFF, 8'hFF, 0);
        end
        chk("sat.cnt8", 32'(err_cnt_o),  32'(5 * RC));
        chk("sat.cnt2", 32'(s_err_cnt),  32'(3 * RC));
        chk("sat.err2", 32'(s_rail_err), 32'(RC));

        // Reset also clears the checker
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.err", 32'(rail_err_o), 32'd0);
        chk("rst2.cnt", 32'(err_cnt_o),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
